// File: rtl/demux4_tdm_if.sv
// Bundle of the TDM input stream and the demuxed channel outputs.
// The source side (master) drives the byte stream and observes the channels;
// the demux (slave) consumes the stream and drives the channels and status.
interface demux4_tdm_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_sof;
    logic [WIDTH-1:0] data0;
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] data2;
    logic [WIDTH-1:0] data3;
    logic             frame_valid;
    logic [1:0]       slot;
    logic             err;
    logic [1:0]       err_code;

    modport master (
        output din, din_valid, din_sof,
        input  data0, data1, data2, data3, frame_valid, slot, err, err_code
    );

    modport slave (
        input  din, din_valid, din_sof,
        output data0, data1, data2, data3, frame_valid, slot, err, err_code
    );
endinterface

// File: rtl/demux4_tdm.sv
// Receive side of the 4:1 TDM byte path. Slots 0..2 of a frame are staged in
// shadow registers; the edge that samples slot 3 loads all four channels at
// once and pulses frame_valid. Missing SOF, early SOF and mid-frame stalls
// are reported as single-cycle err pulses with a held err_code.
module demux4_tdm #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 16   // idle cycles mid-frame before abort; 0 = never
) (
    input  logic         clk,
    input  logic         rst_n,
    demux4_tdm_if.slave  bus
);
    typedef enum logic {
        IDLE,
        COLLECT
    } state_t;

    // The counter only ever needs to reach TIMEOUT-1 before the abort fires.
    localparam int                CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    localparam logic [1:0] ERR_NO_SOF    = 2'b01;
    localparam logic [1:0] ERR_EARLY_SOF = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT   = 2'b11;

    state_t           state_q, state_d;
    logic [1:0]       slot_q, slot_d;
    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic [WIDTH-1:0] shadow_q [3];
    logic [WIDTH-1:0] data_q   [4];
    logic             frame_valid_q;
    logic             err_q, err_d;
    logic [1:0]       err_code_q, err_code_d;
    logic             shadow_we;
    logic [1:0]       shadow_idx;
    logic             frame_load;

    // Next-state, slot tracking, error classification and idle counting.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        slot_d     = slot_q;
        idle_cnt_d = '0;
        shadow_we  = 1'b0;
        shadow_idx = slot_q;
        frame_load = 1'b0;
        err_d      = 1'b0;
        err_code_d = err_code_q;

        unique case (state_q)
            IDLE: begin
                slot_d = 2'd0;
                if (bus.din_valid) begin
                    if (bus.din_sof) begin
                        shadow_we  = 1'b1;
                        shadow_idx = 2'd0;
                        slot_d     = 2'd1;
                        state_d    = COLLECT;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = ERR_NO_SOF;
                    end
                end
            end

            COLLECT: begin
                if (bus.din_valid) begin
                    if (bus.din_sof) begin
                        // Restart: the SOF byte becomes slot 0 of a new frame.
                        err_d      = 1'b1;
                        err_code_d = ERR_EARLY_SOF;
                        shadow_we  = 1'b1;
                        shadow_idx = 2'd0;
                        slot_d     = 2'd1;
                    end else if (slot_q == 2'd3) begin
                        frame_load = 1'b1;
                        slot_d     = 2'd0;
                        state_d    = IDLE;
                    end else begin
                        shadow_we  = 1'b1;
                        slot_d     = slot_q + 2'd1;
                    end
                end else if (TIMEOUT != 0) begin
                    if (idle_cnt_q == CNT_LAST) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_TIMEOUT;
                        slot_d     = 2'd0;
                        state_d    = IDLE;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 1'b1;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State, shadow staging and registered outputs, with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q       <= IDLE;
            slot_q        <= 2'd0;
            idle_cnt_q    <= '0;
            frame_valid_q <= 1'b0;
            err_q         <= 1'b0;
            err_code_q    <= 2'b00;
            // NOTE: the shadow and channel registers are reset explicitly, so
            // they cannot be mapped to RAM; at 7 bytes that is intended.
            for (int i = 0; i < 3; i++) shadow_q[i] <= '0;
            for (int i = 0; i < 4; i++) data_q[i]   <= '0;
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            idle_cnt_q    <= idle_cnt_d;
            frame_valid_q <= frame_load;
            err_q         <= err_d;
            err_code_q    <= err_code_d;
            for (int i = 0; i < 3; i++) begin
                if (shadow_we && shadow_idx == 2'(i)) shadow_q[i] <= bus.din;
            end
            if (frame_load) begin
                data_q[0] <= shadow_q[0];
                data_q[1] <= shadow_q[1];
                data_q[2] <= shadow_q[2];
                data_q[3] <= bus.din;
            end
        end
    end

    assign bus.data0       = data_q[0];
    assign bus.data1       = data_q[1];
    assign bus.data2       = data_q[2];
    assign bus.data3       = data_q[3];
    assign bus.frame_valid = frame_valid_q;
    assign bus.slot        = slot_q;
    assign bus.err         = err_q;
    assign bus.err_code    = err_code_q;
endmodule
